// File: rtl/gray_count_decoder_pkg.sv
// gray_count_decoder_pkg: FSM state and step classification types for the Gray counter receiver
package gray_count_decoder_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, FAULT = 2'd2} state_t;
    typedef enum logic [1:0] {HOLD, UP, DOWN, ILLEGAL} step_t;
endpackage

// File: rtl/gray_count_decoder_if.sv
// gray_count_decoder_if: Gray sample input and decoded status bundle
interface gray_count_decoder_if #(
    parameter int N_BITS    = 5,
    parameter int ERR_CNT_W = 8
);
    logic [1:N_BITS]      gray_in;
    logic                 gray_valid;
    logic [1:N_BITS]      bin_out;
    logic                 bin_valid;
    logic                 dir_up;
    logic                 step_err;
    logic                 locked;
    logic [ERR_CNT_W-1:0] err_count;
    modport master (output gray_in, gray_valid, input bin_out, bin_valid, dir_up, step_err, locked, err_count);
    modport slave  (input gray_in, gray_valid, output bin_out, bin_valid, dir_up, step_err, locked, err_count);
endinterface

// File: rtl/gray_to_bin.sv
// gray_to_bin: combinational MSB-first Gray to binary prefix-XOR converter
module gray_to_bin #(
    parameter int N_BITS = 5
) (
    input  logic [1:N_BITS] gray,
    output logic [1:N_BITS] bin
);
    for (genvar i = 1; i <= N_BITS; i++) begin : g_bit
        assign bin[i] = ^gray[1:i];
    end
endmodule

// File: rtl/gray_count_decoder.sv
// gray_count_decoder: decodes Gray samples, checks single-step motion and tracks lock status
module gray_count_decoder
    import gray_count_decoder_pkg::*;
#(
    parameter int N_BITS     = 5,
    parameter int RELOCK_LEN = 4,
    parameter int ERR_CNT_W  = 8
) (
    input logic Clock,
    input logic Clear,
    gray_count_decoder_if.slave bus
);
    localparam int RC_W = $clog2(RELOCK_LEN + 1);

    logic [1:N_BITS]      s1_gray, cur_bin, delta, bin_out;
    logic                 s1_valid, bin_valid, dir_up, step_err;
    logic                 check, legal, relock_done;
    logic [ERR_CNT_W-1:0] err_count;
    logic [RC_W-1:0]      relock_cnt;
    state_t               state, state_next;
    step_t                step;

    gray_to_bin #(.N_BITS(N_BITS)) u_gray_to_bin (.gray(s1_gray), .bin(cur_bin));

    // Stage 1 capture; data holds across gaps
    always_ff @(posedge Clock) begin
        s1_valid <= !Clear && bus.gray_valid;
        if (!Clear && bus.gray_valid) s1_gray <= bus.gray_in;
    end

    // Classify the step from the last decoded value (bin_out doubles as prev_bin)
    always_comb begin
        delta       = cur_bin - bin_out;
        step        = delta == '0 ? HOLD : delta == N_BITS'(1) ? UP : &delta ? DOWN : ILLEGAL;
        check       = s1_valid && state != IDLE;
        legal       = step != ILLEGAL;
        relock_done = s1_valid && state == FAULT && legal && relock_cnt == RC_W'(RELOCK_LEN - 1);
    end

    // State register
    always_ff @(posedge Clock) begin
        state <= Clear ? IDLE : state_next;
    end

    // Next state, advanced only by decoded samples
    always_comb begin
        state_next = state;
        if (s1_valid)
            state_next = state == IDLE  ? TRACK :
                         state == TRACK ? (legal ? TRACK : FAULT) :
                         (relock_done ? TRACK : FAULT);
    end

    // Stage 2 registered outputs, error counter and relock counter
    always_ff @(posedge Clock) begin
        if (Clear) begin
            bin_out    <= '0;
            bin_valid  <= 1'b0;
            dir_up     <= 1'b0;
            step_err   <= 1'b0;
            err_count  <= '0;
            relock_cnt <= '0;
        end else begin
            bin_valid <= s1_valid;
            step_err  <= check && !legal;
            if (s1_valid) bin_out <= cur_bin;
            if (check && step == UP) dir_up <= 1'b1;
            else if (check && step == DOWN) dir_up <= 1'b0;
            if (check && !legal && !(&err_count)) err_count <= err_count + 1'b1;
            if (s1_valid && state == FAULT) relock_cnt <= (legal && !relock_done) ? relock_cnt + 1'b1 : '0;
        end
    end

    // Drive the bus; locked is a decode of the state register
    always_comb begin
        bus.bin_out   = bin_out;
        bus.bin_valid = bin_valid;
        bus.dir_up    = dir_up;
        bus.step_err  = step_err;
        bus.locked    = state == TRACK;
        bus.err_count = err_count;
    end
endmodule

// File: tb/tb_gray_count_decoder.sv
// tb_gray_count_decoder: directed vectors against a cycle model of the Gray receiver
module tb_gray_count_decoder;
    localparam int N  = 5;
    localparam int RL = 4;
    localparam int EW = 2;
    localparam int M  = 1 << N;

    logic Clock, Clear;
    int checks = 0;
    int errors = 0;

    int m_p1v, m_p1g, m_bin, m_bv, m_dir, m_se, m_mode, m_good, m_errs;

    gray_count_decoder_if #(.N_BITS(N), .ERR_CNT_W(EW)) bus ();

    gray_count_decoder #(.N_BITS(N), .RELOCK_LEN(RL), .ERR_CNT_W(EW)) dut (
        .Clock(Clock),
        .Clear(Clear),
        .bus  (bus)
    );

    initial begin
        Clock = 0;
        forever #5 Clock = ~Clock;
    end

    function automatic int g2b(input int g);
        int b = g;
        for (int s = 1; s < N; s++) b ^= g >> s;
        return b;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: mode 0 = waiting for first sample, 1 = tracking, 2 = faulted
    task automatic model_step();
        int b, d;
        bit ok;
        if (Clear) begin
            m_p1v = 0; m_bin = 0; m_bv = 0; m_dir = 0; m_se = 0; m_mode = 0; m_good = 0; m_errs = 0;
            return;
        end
        m_bv = m_p1v;
        m_se = 0;
        if (m_p1v != 0) begin
            b = g2b(m_p1g);
            d = (b - m_bin + M) % M;
            if (m_mode == 0) m_mode = 1;
            else begin
                ok = d == 0 || d == 1 || d == M - 1;
                if (d == 1) m_dir = 1;
                if (d == M - 1) m_dir = 0;
                if (!ok) begin
                    m_se = 1; m_errs++; m_mode = 2; m_good = 0;
                end else if (m_mode == 2) begin
                    m_good++;
                    if (m_good == RL) begin
                        m_mode = 1; m_good = 0;
                    end
                end
            end
            m_bin = b;
        end
        m_p1v = bus.gray_valid ? 1 : 0;
        if (bus.gray_valid) m_p1g = int'(bus.gray_in);
    endtask

    task automatic compare();
        chk("bin_out", bus.bin_out, m_bin);
        chk("bin_valid", bus.bin_valid, m_bv);
        chk("dir_up", bus.dir_up, m_dir);
        chk("step_err", bus.step_err, m_se);
        chk("locked", bus.locked, m_mode == 1);
        chk("err_count", bus.err_count, m_errs > 3 ? 3 : m_errs);
    endtask

    task automatic tick(input logic v, input logic [N-1:0] g, input logic c);
        bus.gray_valid = v;
        bus.gray_in    = g;
        Clear          = c;
        @(posedge Clock);
        model_step();
        @(negedge Clock);
        compare();
    endtask

    task automatic send(input logic [N-1:0] g);
        tick(1'b1, g, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0);
    endtask

    task automatic clr();
        tick(1'b0, '0, 1'b1);
    endtask

    initial begin
        int ec [5] = '{1, 2, 3, 3, 3};
        logic [N-1:0] sat [5] = '{5'b00000, 5'b11000, 5'b00000, 5'b11000, 5'b00000};
        bus.gray_valid = 0;
        bus.gray_in    = '0;
        Clear          = 1;
        clr();
        clr();
        chk("rst_locked", bus.locked, 0);
        chk("rst_err", bus.err_count, 0);
        // up run
        send(5'b00000);
        chk("lat_nov", bus.bin_valid, 0);
        send(5'b00001);
        chk("lat_bv", bus.bin_valid, 1);
        chk("lat_lock", bus.locked, 1);
        send(5'b00011);
        send(5'b00010);
        idle(1);
        chk("up_bin3", bus.bin_out, 3);
        chk("up_dir", bus.dir_up, 1);
        idle(1);
        // wrap and reverse
        clr();
        send(5'b10000);
        send(5'b00000);
        send(5'b10000);
        chk("wrap_bin0", bus.bin_out, 0);
        chk("wrap_dir_up", bus.dir_up, 1);
        idle(1);
        chk("wrap_bin31", bus.bin_out, 31);
        chk("wrap_dir_dn", bus.dir_up, 0);
        chk("wrap_err", bus.err_count, 0);
        // illegal jump then relock
        clr();
        send(5'b00001);
        send(5'b00110);
        send(5'b00111);
        chk("jump_bin4", bus.bin_out, 4);
        chk("jump_err", bus.step_err, 1);
        chk("jump_cnt", bus.err_count, 1);
        send(5'b00101);
        send(5'b00100);
        send(5'b01100);
        chk("relock_pre", bus.locked, 0);
        idle(1);
        chk("relock_bin8", bus.bin_out, 8);
        chk("relock_lock", bus.locked, 1);
        // gapped input
        send(5'b01101);
        idle(3);
        send(5'b01111);
        idle(7);
        send(5'b01101);
        idle(10);
        chk("gap_bin9", bus.bin_out, 9);
        chk("gap_bv", bus.bin_valid, 0);
        chk("gap_err", bus.err_count, 1);
        // clear while faulted
        send(5'b11110);
        send(5'b00111);
        idle(1);
        chk("pre_clr_cnt", bus.err_count, 3);
        chk("pre_clr_lock", bus.locked, 0);
        clr();
        chk("clr_bin", bus.bin_out, 0);
        chk("clr_cnt", bus.err_count, 0);
        chk("clr_dir", bus.dir_up, 0);
        send(5'b11000);
        idle(1);
        chk("post_clr_bin", bus.bin_out, 16);
        chk("post_clr_lock", bus.locked, 1);
        chk("post_clr_se", bus.step_err, 0);
        // saturation
        for (int i = 0; i < 5; i++) begin
            send(sat[i]);
            if (i > 0) begin
                chk("sat_se", bus.step_err, 1);
                chk("sat_cnt", bus.err_count, ec[i-1]);
            end
        end
        idle(1);
        chk("sat_se_last", bus.step_err, 1);
        chk("sat_cnt_last", bus.err_count, ec[4]);
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gray_count_decoder.md
Name: gray_count_decoder

Overview:
Receiving end of the team's Gray-coded counter bus. Samples an N_BITS Gray word on each qualified cycle and converts it to binary. Checks that consecutive samples differ by exactly one count step (or zero), reports step direction, and tracks lock/fault status. Sits downstream of the Gray counter, e.g. after a clock-domain crossing or a position encoder.

Parameters:
N_BITS, 5, width of Gray input and binary output
RELOCK_LEN, 4, consecutive legal samples required to leave FAULT
ERR_CNT_W, 8, width of saturating error counter

Ports:
Clock  input  1  rising-edge clock
Clear  input  1  synchronous, active-high reset
gray_in  input  [1:N_BITS]  Gray word, MSB-first (bit 1 = MSB)
gray_valid  input  1  qualifies gray_in this cycle
bin_out  output  [1:N_BITS]  decoded binary, MSB-first
bin_valid  output  1  one-cycle pulse per decoded sample
dir_up  output  1  last legal nonzero step was +1 (0 = -1)
step_err  output  1  one-cycle pulse on illegal step
locked  output  1  high in TRACK state
err_count  output  [ERR_CNT_W-1:0]  saturating count of illegal steps

Behaviour:
- Reset: Clear sampled at posedge. All outputs are 0 the cycle after. FSM goes to IDLE; pipeline valids and relock counter are cleared. Clear wins over gray_valid in the same cycle.
- Stage 1: on gray_valid=1, register gray_in and set s1_valid. Otherwise s1_valid=0 and the data is held.
- Stage 2 (registered outputs): convert Gray to binary with b[1]=g[1] and b[i]=b[i-1]^g[i] for i=2..N_BITS.
  - bin_out updates and bin_valid pulses on the edge after stage 1 capture.
  - Latency: exactly 2 Clock edges from the gray_valid sample to bin_valid high.
- Step check: delta = cur_bin - prev_bin, modulo 2^N_BITS. prev_bin is the last decoded value, updated on every s1_valid.
  - delta=0: legal hold; dir_up unchanged.
  - delta=1: legal up; dir_up<=1.
  - delta=all-ones: legal down; dir_up<=0.
  - Any other delta is illegal.
  - Wrap-around is legal in both directions: 2^N-1 -> 0 is up, 0 -> 2^N-1 is down.
- FSM states IDLE, TRACK, FAULT:
  - IDLE: first valid sample loads prev_bin with no check, then goes to TRACK. locked=0.
  - TRACK: a legal sample stays in TRACK. An illegal sample pulses step_err, increments err_count, and goes to FAULT. locked=1.
  - FAULT: locked=0. Each legal sample increments relock_cnt; an illegal sample pulses step_err, increments err_count, and resets relock_cnt to 0. When relock_cnt reaches RELOCK_LEN, go to TRACK on that same edge and clear relock_cnt.
- step_err, locked and dir_up are aligned with the bin_valid of the offending sample.
- In FAULT, prev_bin still tracks the latest sample, so relocking follows the new sequence.
- err_count saturates at all-ones and never wraps. Only Clear clears it.
- Cycles with gray_valid=0 cause no checks and no state change. Gaps of any length are allowed.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, TRACK=2'd1, FAULT=2'd2) and the delta classification constants (HOLD, UP, DOWN, ILLEGAL).
- One natural sub-module: gray_to_bin, a purely combinational N_BITS prefix-XOR converter, reusable elsewhere.
- Step classification and the FSM stay in the top module.

Test Plan:
- Up run, N_BITS=5: after Clear, feed gray 00000, 00001, 00011, 00010 on consecutive cycles -> bin_out 0, 1, 2, 3 each 2 edges after input. locked=1 from the 1st bin_valid; dir_up=1; no step_err.
- Wrap and reverse: feed 10000 (31), 00000 (0), then 10000 (31) -> binaries 31, 0, 31. dir_up goes 1 then 0; no step_err; err_count=0.
- Illegal jump: feed 00001 (1) then 00110 (4) -> step_err pulses once with bin_out=4, err_count=1, locked=0. Then 4 legal up steps (00111, 00101, 00100, 01100) -> locked=1 on the 4th bin_valid.
- Gapped input: feed legal samples with gray_valid low for 3 to 10 cycles between them -> outputs hold, no bin_valid during gaps, no errors.
- Clear mid-stream: assert Clear for 1 cycle while in FAULT with err_count=3 -> next cycle all outputs 0, state IDLE. The next sample (gray 11000 = 16) gives no step_err and locked=1.
- Saturation, ERR_CNT_W=2: force 5 illegal jumps -> err_count reads 1, 2, 3, 3, 3; step_err pulses all 5 times.
